// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the 16-bit MIPS pipelined datapath.
//   DATA_W / ADDR_W / CNT_W : datapath, register-address and counter widths
//   REG_ZERO                : architectural zero register (never forwarded)
//   ex_ctrl_t               : control bundle carried by the ID/EX register
//   load_use_hazard()       : producer-is-a-pending-load dependency test
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 4'b0000;

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic              is_load;
    logic [ADDR_W-1:0] rd_addr;
  } ex_ctrl_t;

  // True when a load in flight writes a register the ID instruction reads.
  // r0 is excluded because reads of r0 always resolve to zero.
  function automatic logic load_use_hazard(
    input logic              prod_valid,
    input logic              prod_is_load,
    input logic              prod_wr_en,
    input logic [ADDR_W-1:0] prod_addr,
    input logic [ADDR_W-1:0] rs_addr,
    input logic [ADDR_W-1:0] rt_addr,
    input logic              rt_used
  );
    return prod_valid & prod_is_load & prod_wr_en & (prod_addr != REG_ZERO) &
           ((prod_addr == rs_addr) | (rt_used & (prod_addr == rt_addr)));
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_if
// Bundle of everything the ID/EX operand stage exchanges with the pipeline:
//   id_*     : decoded ID instruction and register-file read data
//   exmem_*  : EX/MEM producer (bypass source, possibly a pending load)
//   memwb_*  : MEM/WB producer (register-file write port this cycle)
//   flush    : branch-taken kill of the ID instruction
//   stall_out, ex_*, stall_count : stage outputs
// modport master : the surrounding pipeline (drives ID/bypass, sees EX)
// modport slave  : the operand stage itself
// ---------------------------------------------------------------------------
interface id_ex_if #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int CNT_W  = pipe_pkg::CNT_W
) ();

  // ID stage
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_rt_used;
  logic [ADDR_W-1:0] id_rd_addr;
  logic              id_wr_en;
  logic              id_is_load;
  logic [DATA_W-1:0] id_rf_a;
  logic [DATA_W-1:0] id_rf_b;
  logic [DATA_W-1:0] id_imm;

  // EX/MEM producer
  logic              exmem_wr_en;
  logic [ADDR_W-1:0] exmem_waddr;
  logic [DATA_W-1:0] exmem_data;
  logic              exmem_is_load;

  // MEM/WB producer
  logic              memwb_wr_en;
  logic [ADDR_W-1:0] memwb_waddr;
  logic [DATA_W-1:0] memwb_data;

  logic              flush;

  // Stage outputs
  logic              stall_out;
  logic              ex_valid;
  logic              ex_wr_en;
  logic              ex_is_load;
  logic [ADDR_W-1:0] ex_rd_addr;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [DATA_W-1:0] ex_imm;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rt_used, id_rd_addr,
           id_wr_en, id_is_load, id_rf_a, id_rf_b, id_imm,
           exmem_wr_en, exmem_waddr, exmem_data, exmem_is_load,
           memwb_wr_en, memwb_waddr, memwb_data, flush,
    input  stall_out, ex_valid, ex_wr_en, ex_is_load, ex_rd_addr,
           ex_op_a, ex_op_b, ex_imm, stall_count
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rt_used, id_rd_addr,
           id_wr_en, id_is_load, id_rf_a, id_rf_b, id_imm,
           exmem_wr_en, exmem_waddr, exmem_data, exmem_is_load,
           memwb_wr_en, memwb_waddr, memwb_data, flush,
    output stall_out, ex_valid, ex_wr_en, ex_is_load, ex_rd_addr,
           ex_op_a, ex_op_b, ex_imm, stall_count
  );

endinterface

// File: rtl/operand_bypass_mux.sv
// ---------------------------------------------------------------------------
// operand_bypass_mux
// Combinational operand select for one source register.
//   src_i                      : source register address
//   rf_data_i                  : register-file read data for src_i
//   exmem_* / memwb_*          : younger / older producers
//   operand_o                  : resolved operand
// Priority: r0 -> 0, EX/MEM (non-load) -> MEM/WB -> register file.
// The register file writes on the same edge MEM/WB presents its data, so
// its read port still shows the old value; MEM/WB must be bypassed here.
// ---------------------------------------------------------------------------
module operand_bypass_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_wr_en_i,
  input  logic              exmem_is_load_i,
  input  logic [ADDR_W-1:0] exmem_waddr_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_wr_en_i,
  input  logic [ADDR_W-1:0] memwb_waddr_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] operand_o
);

  logic exmem_hit;
  logic memwb_hit;

  // A load in EX/MEM has no data yet; the hazard logic stalls instead.
  assign exmem_hit = exmem_wr_en_i & ~exmem_is_load_i & (exmem_waddr_i == src_i);
  assign memwb_hit = memwb_wr_en_i & (memwb_waddr_i == src_i);

  always_comb begin
    operand_o = rf_data_i;
    if (src_i == REG_ZERO) begin
      operand_o = '0;
    end else if (exmem_hit) begin
      operand_o = exmem_data_i;
    end else if (memwb_hit) begin
      operand_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register with ID-stage bypassing and load-use stalling.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : id_ex_if.slave -- ID inputs, EX/MEM + MEM/WB bypass sources,
//          flush, and the registered EX outputs, stall_out, stall_count
// A load directly ahead of a dependent instruction stalls 2 cycles (seen
// first in EX, then in EX/MEM); one slot further back stalls 1 cycle.
// ---------------------------------------------------------------------------
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic    clk,
  input  logic    rst,
  id_ex_if.slave  bus
);

  localparam int NUM_SRC = 2;

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] src_addr [NUM_SRC];
  logic [DATA_W-1:0] src_rf   [NUM_SRC];
  logic [DATA_W-1:0] src_fwd  [NUM_SRC];

  logic haz_ex;
  logic haz_mem;
  logic stall;

  // Source 0 feeds operand A (rs), source 1 feeds operand B (rt).
  assign src_addr[0] = bus.id_rs_addr;
  assign src_addr[1] = bus.id_rt_addr;
  assign src_rf[0]   = bus.id_rf_a;
  assign src_rf[1]   = bus.id_rf_b;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_bypass
      operand_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_mux (
        .src_i           (src_addr[gi]),
        .rf_data_i       (src_rf[gi]),
        .exmem_wr_en_i   (bus.exmem_wr_en),
        .exmem_is_load_i (bus.exmem_is_load),
        .exmem_waddr_i   (bus.exmem_waddr),
        .exmem_data_i    (bus.exmem_data),
        .memwb_wr_en_i   (bus.memwb_wr_en),
        .memwb_waddr_i   (bus.memwb_waddr),
        .memwb_data_i    (bus.memwb_data),
        .operand_o       (src_fwd[gi])
      );
    end
  endgenerate

  // EX/MEM carries only register-writing instructions, so it counts as valid.
  assign haz_ex  = load_use_hazard(ctrl_q.valid, ctrl_q.is_load, ctrl_q.wr_en,
                                   ctrl_q.rd_addr, bus.id_rs_addr,
                                   bus.id_rt_addr, bus.id_rt_used);
  assign haz_mem = load_use_hazard(1'b1, bus.exmem_is_load, bus.exmem_wr_en,
                                   bus.exmem_waddr, bus.id_rs_addr,
                                   bus.id_rt_addr, bus.id_rt_used);

  // A flushed instruction is dead, so it must never hold the front end.
  assign stall = bus.id_valid & ~bus.flush & ~rst & (haz_ex | haz_mem);

  always_comb begin
    ctrl_d = ctrl_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    imm_d  = imm_q;
    cnt_d  = cnt_q;
    if (bus.flush) begin
      ctrl_d.valid   = 1'b0;
      ctrl_d.wr_en   = 1'b0;
      ctrl_d.is_load = 1'b0;
    end else if (stall) begin
      ctrl_d.valid   = 1'b0;
      ctrl_d.wr_en   = 1'b0;
      ctrl_d.is_load = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      ctrl_d.valid   = bus.id_valid;
      ctrl_d.wr_en   = bus.id_wr_en & bus.id_valid;
      ctrl_d.is_load = bus.id_is_load & bus.id_valid;
      ctrl_d.rd_addr = bus.id_rd_addr;
      op_a_d         = src_fwd[0];
      op_b_d         = src_fwd[1];
      imm_d          = bus.id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      imm_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      imm_q  <= imm_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.stall_out   = stall;
  assign bus.ex_valid    = ctrl_q.valid;
  assign bus.ex_wr_en    = ctrl_q.wr_en;
  assign bus.ex_is_load  = ctrl_q.is_load;
  assign bus.ex_rd_addr  = ctrl_q.rd_addr;
  assign bus.ex_op_a     = op_a_q;
  assign bus.ex_op_b     = op_b_q;
  assign bus.ex_imm      = imm_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        chk_data;
    logic        valid;
    logic        wr_en;
    logic        is_load;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic rt_used, input logic [3:0] rd, input logic wr,
                        input logic ld, input logic [15:0] rfa, input logic [15:0] rfb,
                        input logic [15:0] imm);
    bus.id_valid   = v;
    bus.id_rs_addr = rs;
    bus.id_rt_addr = rt;
    bus.id_rt_used = rt_used;
    bus.id_rd_addr = rd;
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.id_rf_a    = rfa;
    bus.id_rf_b    = rfb;
    bus.id_imm     = imm;
  endtask

  task automatic set_fwd(input logic ew, input logic [3:0] ea, input logic [15:0] ed,
                         input logic el, input logic mw, input logic [3:0] ma,
                         input logic [15:0] md);
    bus.exmem_wr_en   = ew;
    bus.exmem_waddr   = ea;
    bus.exmem_data    = ed;
    bus.exmem_is_load = el;
    bus.memwb_wr_en   = mw;
    bus.memwb_waddr   = ma;
    bus.memwb_data    = md;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle(input string tag, input logic exp_stall, input logic chk,
                           input logic v, input logic w, input logic l,
                           input logic [3:0] rd, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] imm,
                           input logic [15:0] cnt);
    exp_t e;
    #1;
    check({tag, ".stall_out"}, 32'(bus.stall_out), 32'(exp_stall));
    e.tag = tag; e.chk_data = chk; e.valid = v; e.wr_en = w; e.is_load = l;
    e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.cnt = cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".ex_valid"},    32'(bus.ex_valid),    32'(e.valid));
    check({e.tag, ".ex_wr_en"},    32'(bus.ex_wr_en),    32'(e.wr_en));
    check({e.tag, ".ex_is_load"},  32'(bus.ex_is_load),  32'(e.is_load));
    check({e.tag, ".stall_count"}, 32'(bus.stall_count), 32'(e.cnt));
    if (e.chk_data) begin
      check({e.tag, ".ex_rd_addr"}, 32'(bus.ex_rd_addr), 32'(e.rd));
      check({e.tag, ".ex_op_a"},    32'(bus.ex_op_a),    32'(e.a));
      check({e.tag, ".ex_op_b"},    32'(bus.ex_op_b),    32'(e.b));
      check({e.tag, ".ex_imm"},     32'(bus.ex_imm),     32'(e.imm));
    end
    $display("[TB] %-10s stall=%0b valid=%0b wr=%0b ld=%0b rd=%0d a=0x%04h b=0x%04h imm=0x%04h cnt=%0d",
             e.tag, exp_stall, bus.ex_valid, bus.ex_wr_en, bus.ex_is_load,
             bus.ex_rd_addr, bus.ex_op_a, bus.ex_op_b, bus.ex_imm, bus.stall_count);
    @(negedge clk);
  endtask

  initial begin
    bus.flush = 1'b0;
    set_id(1, 6, 2, 1, 7, 1, 0, 16'h0005, 16'h0004, 16'h0000);
    // Pending load in EX/MEM targeting r6: would stall except for reset.
    set_fwd(1, 6, 16'h0000, 1, 0, 0, 16'h0000);
    rst = 1'b1;
    @(negedge clk);

    run_cycle("reset0", 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);
    run_cycle("reset1", 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);

    rst = 1'b0;
    set_id(1, 6, 2, 1, 7, 1, 0, 16'h0005, 16'h0004, 16'h0011);
    set_fwd(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    run_cycle("pass", 0, 1, 1, 1, 0, 7, 16'h0005, 16'h0004, 16'h0011, 16'd0);

    set_id(1, 12, 2, 1, 8, 0, 0, 16'h0101, 16'h0004, 16'h0022);
    set_fwd(1, 12, 16'h00AA, 0, 1, 12, 16'h0055);
    run_cycle("byp_exmem", 0, 1, 1, 0, 0, 8, 16'h00AA, 16'h0004, 16'h0022, 16'd0);

    set_fwd(0, 12, 16'h00AA, 0, 1, 12, 16'h0055);
    run_cycle("byp_memwb", 0, 1, 1, 0, 0, 8, 16'h0055, 16'h0004, 16'h0022, 16'd0);

    set_id(1, 0, 0, 1, 9, 1, 0, 16'h0077, 16'h0088, 16'h0033);
    set_fwd(1, 0, 16'h00AA, 0, 1, 0, 16'h0055);
    run_cycle("byp_r0", 0, 1, 1, 1, 0, 9, 16'h0000, 16'h0000, 16'h0033, 16'd0);

    // Load r3, then a dependent instruction reading rs=3.
    set_id(1, 1, 2, 0, 3, 1, 1, 16'h0100, 16'h0200, 16'h0004);
    set_fwd(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    run_cycle("load_r3", 0, 1, 1, 1, 1, 3, 16'h0100, 16'h0200, 16'h0004, 16'd0);

    set_id(1, 3, 4, 1, 5, 1, 0, 16'hDEAD, 16'h0044, 16'h0008);
    run_cycle("lu_stall1", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd1);

    set_fwd(1, 3, 16'h0000, 1, 0, 0, 16'h0000);
    run_cycle("lu_stall2", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd2);

    set_fwd(0, 0, 16'h0000, 0, 1, 3, 16'h1234);
    run_cycle("lu_issue", 0, 1, 1, 1, 0, 5, 16'h1234, 16'h0044, 16'h0008, 16'd2);

    // Load r3 ahead, rt=3 but rt unused: no stall.
    set_id(1, 1, 2, 0, 3, 1, 1, 16'h0100, 16'h0200, 16'h0004);
    set_fwd(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    run_cycle("load_r3b", 0, 1, 1, 1, 1, 3, 16'h0100, 16'h0200, 16'h0004, 16'd2);

    set_id(1, 5, 3, 0, 6, 1, 0, 16'h0055, 16'h0066, 16'h0010);
    run_cycle("rt_unused", 0, 1, 1, 1, 0, 6, 16'h0055, 16'h0066, 16'h0010, 16'd2);

    // Load two behind on the rt path: one stall.
    set_id(1, 5, 3, 1, 6, 1, 0, 16'h0055, 16'h0066, 16'h0010);
    set_fwd(1, 3, 16'h0000, 1, 0, 0, 16'h0000);
    run_cycle("rt_stall", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd3);

    bus.flush = 1'b1;
    run_cycle("flush", 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd3);

    bus.flush = 1'b0;
    rst = 1'b1;
    run_cycle("rst_stall", 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'd0);

    rst = 1'b0;
    set_id(0, 7, 8, 1, 10, 1, 1, 16'h0070, 16'h0080, 16'h0090);
    set_fwd(0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    run_cycle("idle", 0, 1, 0, 0, 0, 10, 16'h0070, 16'h0080, 16'h0090, 16'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the 16-bit MIPS pipelined datapath, directly downstream of the 16x16 register file.
- Captures the register-file read ports A/B plus the decoded fields, and applies ID-stage bypassing from EX/MEM and MEM/WB.
- Detects load-use hazards and stalls IF/ID, inserting bubbles into EX.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 16, datapath width; matches register file word.
- ADDR_W, 4, register address width (16 registers).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a live instruction
- id_rs_addr  in  ADDR_W  source register 1 (drives register file Aaddr)
- id_rt_addr  in  ADDR_W  source register 2 (drives register file Baddr)
- id_rt_used  in  1  instruction reads rt (R-type/store/branch)
- id_rd_addr  in  ADDR_W  destination register
- id_wr_en  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- id_rf_a  in  DATA_W  register file A output
- id_rf_b  in  DATA_W  register file B output
- id_imm  in  DATA_W  sign-extended immediate
- exmem_wr_en  in  1  EX/MEM instruction writes a register
- exmem_waddr  in  ADDR_W  EX/MEM destination
- exmem_data  in  DATA_W  EX/MEM ALU result
- exmem_is_load  in  1  EX/MEM instruction is a load (data not yet available)
- memwb_wr_en  in  1  register file load (write enable) this cycle
- memwb_waddr  in  ADDR_W  register file Caddr this cycle
- memwb_data  in  DATA_W  register file C this cycle
- flush  in  1  kill the ID instruction (branch taken)
- stall_out  out  1  hold PC and IF/ID
- ex_valid, ex_wr_en, ex_is_load  out  1 each  registered control
- ex_rd_addr  out  ADDR_W  registered destination
- ex_op_a, ex_op_b, ex_imm  out  DATA_W  registered operands
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: every output register is 0 (ex_valid=0, operands 0, stall_count=0). stall_out is 0 while rst=1.
- Operand select, combinational, applied per source (src = rs for A, rt for B). Priority:
  - src==0 gives 0.
  - Otherwise exmem_wr_en & !exmem_is_load & exmem_waddr==src gives exmem_data.
  - Otherwise memwb_wr_en & memwb_waddr==src gives memwb_data. The register file writes on the same edge and returns the old value during that cycle.
  - Otherwise id_rf_a / id_rf_b.
- Hazard, combinational:
  - haz_ex = ex_valid & ex_is_load & ex_wr_en & ex_rd_addr!=0 & (ex_rd_addr==rs | (id_rt_used & ex_rd_addr==rt)).
  - haz_mem = same test using exmem_is_load, exmem_wr_en and exmem_waddr.
  - stall_out = id_valid & !flush & !rst & (haz_ex | haz_mem).
  - A load immediately followed by a dependent instruction stalls exactly 2 cycles. A dependent instruction two behind the load stalls 1 cycle.
- Pipeline register update each posedge clk, in priority order:
  - rst: clear all.
  - flush: ex_valid, ex_wr_en, ex_is_load ← 0; data fields don't-care; stall_count unchanged.
  - stall_out: insert a bubble (ex_valid, ex_wr_en, ex_is_load ← 0); stall_count += 1, saturating at all-ones.
  - Otherwise: capture ex_valid←id_valid, ex_wr_en←id_wr_en&id_valid, ex_is_load←id_is_load&id_valid, ex_rd_addr, ex_op_a/b (forwarded), ex_imm.
- Latency: 1 cycle from ID to EX outputs.
- A write to r0 is never forwarded (address-0 rule wins).
- Simultaneous EX/MEM and MEM/WB match on the same register: EX/MEM (younger) wins.
- Reset asserted mid-stall: the next edge clears state and stall_out drops the same cycle.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W, ADDR_W constants.
  - REG_ZERO = 4'b0000.
  - ex-stage control bundle typedef (valid, wr_en, is_load, rd_addr).
- One sub-module, operand_bypass_mux: the combinational per-source select. Instantiated twice (A and B) and reused by later stages.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 → all ex_* = 0, stall_count=0, stall_out=0.
- Plain pass: rs=6 with id_rf_a=5, rt=2 with id_rf_b=4, no writes → next cycle ex_op_a=5, ex_op_b=4, ex_valid=1.
- Bypass priority: rs=12, exmem (r12, 0x00AA, not load) and memwb (r12, 0x0055) both active → ex_op_a=0x00AA. Drop exmem → 0x0055. Also rs=0 with both active targeting r0 → ex_op_a=0.
- Load-use: load r3 captured into EX, then ID reads rs=3 → stall_out=1 for 2 cycles, 2 bubbles (ex_valid=0), stall_count=2. Third cycle ex_op_a=memwb_data (e.g. 0x1234).
- rt not used: load r3 ahead, ID rt=3 with id_rt_used=0 → no stall.
- Flush during stall: hazard active with flush=1 → stall_out=0, ex_valid=0 next cycle, stall_count unchanged.
